// File: rtl/perf_cnt_arbiter.sv
// Cycle / retired-instruction counters with a round-robin shared readout port.
// Optional macro PERF_OVF_EN: counters wrap and report sticky overflow on ovf.
module perf_cnt_arbiter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [3:0]       ex,
   input  logic             ctrl_start,
   input  logic             ctrl_stop,
   input  logic             ctrl_clear,
   input  logic [3:0]       req,
   output logic [3:0]       gnt,
   output logic             rd_valid,
   output logic             rd_last,
   output logic [1:0]       rd_id,
   output logic [CNT_W-1:0] rd_data,
   output logic             running,
   output logic             busy
`ifdef PERF_OVF_EN
   ,
   output logic [1:0]       ovf
`endif
);

   typedef enum logic [1:0] {IDLE, SNAP, XFER0, XFER1} state_t;

   state_t           state_reg, state_next;
   logic             run_reg, run_next;
   logic [CNT_W-1:0] cycle_reg, cycle_next;
   logic [CNT_W-1:0] instr_reg, instr_next;
   logic [CNT_W-1:0] snap_cyc_reg, snap_cyc_next;
   logic [CNT_W-1:0] snap_ins_reg, snap_ins_next;
   logic [3:0]       gnt_reg, gnt_next;
   logic [1:0]       id_reg, id_next;
   logic [1:0]       ptr_reg, ptr_next;
   logic [1:0]       ovf_reg, ovf_next;
   logic [2:0]       pop;
   logic [CNT_W:0]   cyc_sum, ins_sum;
   logic [1:0]       pick_id, cand;
   logic             pick_found;

   // Sums carry one extra bit so the carry-out flags saturation or wrap.
   always_comb begin
      pop = 3'd0;
      for (int k = 0; k < 4; k++) pop = pop + 3'(ex[k]);
      cyc_sum = {1'b0, cycle_reg} + {{CNT_W{1'b0}}, 1'b1};
      ins_sum = {1'b0, instr_reg} + {{(CNT_W-2){1'b0}}, pop};
   end

   always_comb begin
      run_next   = run_reg;
      cycle_next = cycle_reg;
      instr_next = instr_reg;
      ovf_next   = ovf_reg;
      if (ctrl_clear) begin
         cycle_next = '0;
         instr_next = '0;
         ovf_next   = 2'b00;
      end else begin
         if (run_reg) begin
`ifdef PERF_OVF_EN
            cycle_next = cyc_sum[CNT_W-1:0];
            instr_next = ins_sum[CNT_W-1:0];
            ovf_next   = ovf_reg | {ins_sum[CNT_W], cyc_sum[CNT_W]};
`else
            cycle_next = cyc_sum[CNT_W] ? {CNT_W{1'b1}} : cyc_sum[CNT_W-1:0];
            instr_next = ins_sum[CNT_W] ? {CNT_W{1'b1}} : ins_sum[CNT_W-1:0];
`endif
         end
         if (ctrl_stop)       run_next = 1'b0;
         else if (ctrl_start) run_next = 1'b1;
      end
   end

   // Scan from the highest offset down so the nearest requester after ptr wins.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = ptr_reg;
      cand       = ptr_reg;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_reg + 2'(k);
         if (req[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      gnt_next      = gnt_reg;
      id_next       = id_reg;
      ptr_next      = ptr_reg;
      snap_cyc_next = snap_cyc_reg;
      snap_ins_next = snap_ins_reg;
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               gnt_next   = 4'b0001 << pick_id;
               id_next    = pick_id;
               state_next = SNAP;
            end
         end
         SNAP: begin
            snap_cyc_next = cycle_reg;
            snap_ins_next = instr_reg;
            state_next    = XFER0;
         end
         XFER0: state_next = XFER1;
         XFER1: begin
            ptr_next   = id_reg + 2'd1;
            gnt_next   = 4'b0000;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         run_reg      <= 1'b0;
         cycle_reg    <= '0;
         instr_reg    <= '0;
         snap_cyc_reg <= '0;
         snap_ins_reg <= '0;
         gnt_reg      <= 4'b0000;
         id_reg       <= 2'd0;
         ptr_reg      <= 2'd0;
         ovf_reg      <= 2'b00;
      end else begin
         state_reg    <= state_next;
         run_reg      <= run_next;
         cycle_reg    <= cycle_next;
         instr_reg    <= instr_next;
         snap_cyc_reg <= snap_cyc_next;
         snap_ins_reg <= snap_ins_next;
         gnt_reg      <= gnt_next;
         id_reg       <= id_next;
         ptr_reg      <= ptr_next;
         ovf_reg      <= ovf_next;
      end
   end

   assign gnt      = gnt_reg;
   assign rd_id    = id_reg;
   assign running  = run_reg;
   assign busy     = (state_reg != IDLE);
   assign rd_valid = (state_reg == XFER0) || (state_reg == XFER1);
   assign rd_last  = (state_reg == XFER1);
   assign rd_data  = (state_reg == XFER0) ? snap_cyc_reg :
                     (state_reg == XFER1) ? snap_ins_reg : '0;
`ifdef PERF_OVF_EN
   assign ovf = ovf_reg;
`else
   // Overflow tracking only exists in the wrapping build.
   logic unused_ovf;
   assign unused_ovf = ^ovf_reg ^ ^ovf_next;
`endif

endmodule
